// File: rtl/uart_io_fifo_if.sv
// Purpose: handshake bundle between the CPU-side UART port, the serial
// UART TX/RX blocks and the uart_io_fifo buffer.
//   CPU store path : DataIn, DataInValid -> ; <- DataInReady
//   CPU load path  : <- DataOut, DataOutValid ; DataOutReady ->
//   UART TX        : <- tx_data, tx_valid ; tx_ready ->
//   UART RX        : rx_data, rx_valid ->
//   Status/control : ovf_clear -> ; <- tx_overflow, rx_overflow, tx_count, rx_count
// slave  = the FIFO block, master = everything driving it.
interface uart_io_fifo_if #(
  parameter int unsigned AW = 3
);
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady;
  logic [7:0]  DataOut;
  logic        DataOutValid;
  logic        DataOutReady;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ovf_clear;
  logic        tx_overflow;
  logic        rx_overflow;
  logic [AW:0] rx_count;
  logic [AW:0] tx_count;

  modport slave (
    input  DataIn, DataInValid, DataOutReady, tx_ready, rx_data, rx_valid, ovf_clear,
    output DataInReady, DataOut, DataOutValid, tx_data, tx_valid,
           tx_overflow, rx_overflow, rx_count, tx_count
  );

  modport master (
    output DataIn, DataInValid, DataOutReady, tx_ready, rx_data, rx_valid, ovf_clear,
    input  DataInReady, DataOut, DataOutValid, tx_data, tx_valid,
           tx_overflow, rx_overflow, rx_count, tx_count
  );
endinterface

// File: rtl/uart_io_fifo.sv
// Purpose: two independent first-word-fall-through byte FIFOs between the
// CPU's memory-mapped UART handshake and the serial UART.
//   TX FIFO: CPU (DataIn/DataInValid) -> UART transmitter (tx_data/tx_valid/tx_ready)
//   RX FIFO: UART receiver (rx_data/rx_valid) -> CPU (DataOut/DataOutValid/DataOutReady)
// Ports:
//   CLK      rising-edge system clock
//   reset_n  synchronous active-low reset
//   bus      uart_io_fifo_if.slave carrying all data, strobes, flags and counts
// Full/empty come from the registered counts only, so ready/valid status has
// no combinational path from any input strobe.
module uart_io_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic           CLK,
  input logic           reset_n,
  uart_io_fifo_if.slave bus
);

  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------- TX FIFO state ----------------
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr_ptr;
  logic [AW-1:0] r_tx_rd_ptr;
  logic [CW-1:0] r_tx_count;
  logic          r_tx_overflow;

  // ---------------- RX FIFO state ----------------
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wr_ptr;
  logic [AW-1:0] r_rx_rd_ptr;
  logic [CW-1:0] r_rx_count;
  logic          r_rx_overflow;

  logic w_tx_full;
  logic w_tx_empty;
  logic w_tx_push;
  logic w_tx_pop;
  logic w_rx_full;
  logic w_rx_empty;
  logic w_rx_push;
  logic w_rx_pop;

  // Push/pop qualification; a push into a full FIFO is rejected even if a
  // pop frees an entry in the same cycle.
  assign w_tx_full  = (r_tx_count == FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_push  = bus.DataInValid & ~w_tx_full;
  assign w_tx_pop   = bus.tx_ready & ~w_tx_empty;

  assign w_rx_full  = (r_rx_count == FULL_CNT);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_push  = bus.rx_valid & ~w_rx_full;
  assign w_rx_pop   = bus.DataOutReady & ~w_rx_empty;

  // TX storage: not reset, contents are only meaningful under count.
  always_ff @(posedge CLK) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr] <= bus.DataIn;
    end
  end

  // TX pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_tx_wr_ptr   <= '0;
      r_tx_rd_ptr   <= '0;
      r_tx_count    <= '0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_tx_push) begin
        r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
      end
      if (w_tx_pop) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CW'(1);
        2'b01:   r_tx_count <= r_tx_count - CW'(1);
        default: r_tx_count <= r_tx_count;
      endcase
      // A new overflow event outranks a clear in the same cycle.
      if (bus.DataInValid & w_tx_full) begin
        r_tx_overflow <= 1'b1;
      end else if (bus.ovf_clear) begin
        r_tx_overflow <= 1'b0;
      end
    end
  end

  // RX storage: not reset, contents are only meaningful under count.
  always_ff @(posedge CLK) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr_ptr] <= bus.rx_data;
    end
  end

  // RX pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_rx_wr_ptr   <= '0;
      r_rx_rd_ptr   <= '0;
      r_rx_count    <= '0;
      r_rx_overflow <= 1'b0;
    end else begin
      if (w_rx_push) begin
        r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
      end
      if (w_rx_pop) begin
        r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CW'(1);
        2'b01:   r_rx_count <= r_rx_count - CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase
      if (bus.rx_valid & w_rx_full) begin
        r_rx_overflow <= 1'b1;
      end else if (bus.ovf_clear) begin
        r_rx_overflow <= 1'b0;
      end
    end
  end

  // Outputs: status from registered state, heads read combinationally (FWFT).
  assign bus.DataInReady  = ~w_tx_full;
  assign bus.tx_valid     = ~w_tx_empty;
  assign bus.tx_data      = r_tx_mem[r_tx_rd_ptr];
  assign bus.tx_count     = r_tx_count;
  assign bus.tx_overflow  = r_tx_overflow;

  assign bus.DataOutValid = ~w_rx_empty;
  assign bus.DataOut      = r_rx_mem[r_rx_rd_ptr];
  assign bus.rx_count     = r_rx_count;
  assign bus.rx_overflow  = r_rx_overflow;

endmodule

// File: doc/uart_io_fifo.md
Name: uart_io_fifo

Overview:
- Buffers bytes between the CPU datapath's memory-mapped UART handshake (DataIn/DataInValid, DataOut/DataOutValid/DataOutReady) and the serial UART transmitter/receiver.
- Contains two independent FIFOs:
  - TX: CPU to UART transmitter.
  - RX: UART receiver to CPU.
- Sits directly downstream of the datapath's UART select/write-back logic. The CPU can therefore issue back-to-back stores and loads without waiting a serial frame time per byte.

Parameters:
- DEPTH, 8, entries per FIFO; must be a power of 2, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- DataIn  input  8  byte from the CPU store path.
- DataInValid  input  1  one-cycle push strobe into the TX FIFO.
- DataInReady  output  1  TX FIFO not full.
- DataOut  output  8  RX FIFO head byte (first-word fall-through).
- DataOutValid  output  1  RX FIFO not empty.
- DataOutReady  input  1  one-cycle pop strobe from the RX FIFO.
- tx_data  output  8  TX FIFO head byte to the UART transmitter.
- tx_valid  output  1  TX FIFO not empty.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe: rx_data is valid.
- ovf_clear  input  1  clears both sticky error flags.
- tx_overflow  output  1  sticky: a push was attempted while the TX FIFO was full.
- rx_overflow  output  1  sticky: a receive byte was dropped because the RX FIFO was full.
- rx_count  output  AW+1  RX occupancy, 0..DEPTH.
- tx_count  output  AW+1  TX occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n=0 at a CLK edge):
  - All pointers and counts go to 0; both sticky flags go to 0.
  - DataInReady=1, DataOutValid=0, tx_valid=0.
  - DataOut and tx_data are don't-care while the matching valid is 0.
  - Storage contents are not cleared.
  - Reset mid-transfer discards all queued bytes. The first cycle after reset release is a normal cycle.
- Each FIFO has:
  - a DEPTH x 8 register array;
  - wr_ptr and rd_ptr of AW bits, wrapping modulo DEPTH;
  - a count of AW+1 bits.
- full is defined as count==DEPTH; empty is defined as count==0. Both are derived from count, never from pointer equality.
- Push/pop rules:
  - Push writes mem[wr_ptr] and increments wr_ptr.
  - Pop increments rd_ptr.
  - The head byte is mem[rd_ptr], read combinationally, with zero-cycle read latency.
- TX FIFO:
  - push = DataInValid & ~full.
  - pop = tx_valid & tx_ready.
- RX FIFO:
  - push = rx_valid & ~full.
  - pop = DataOutReady & DataOutValid.
- Count updates, per FIFO:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Simultaneous push and pop when full: the pop frees an entry but push is gated by the registered full state. The push is rejected and the overflow flag is set (see below).
- Simultaneous push and pop when empty: a pop requires valid, so only the push takes effect. A byte written at edge N becomes visible on DataOut or tx_data after edge N, with valid=1 in cycle N+1.
- Pop with an empty FIFO: ignored; pointers and count unchanged.
- Latency, push to visible head on an empty FIFO: 1 cycle.
- Throughput: 1 byte per cycle per FIFO.
- Overflow flags:
  - tx_overflow is set on DataInValid & full.
  - rx_overflow is set on rx_valid & full.
  - The offending byte is dropped; FIFO contents are unchanged.
  - Flags hold until ovf_clear=1 or reset.
  - If ovf_clear and a new set event occur in the same cycle, set wins (flag = 1).
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. FIFO order is preserved across the wrap.
- Status outputs DataInReady, DataOutValid, tx_valid and the counts come from registered count, with no combinational path from any input strobe.

Test Plan:
- Reset and empty state:
  - Hold reset_n=0 for 2 cycles with all strobes high, then release.
  - Required: DataInReady=1, DataOutValid=0, tx_valid=0, counts=0, flags=0.
- TX ordering:
  - With tx_ready=0, push 0x41, 0x42, 0x43 on consecutive cycles.
  - Required: tx_count=3, tx_data=0x41.
  - Then raise tx_ready. Required: tx_data sequence 0x41, 0x42, 0x43 on successive cycles, then tx_valid=0.
- TX full and overflow:
  - With tx_ready=0, push 9 bytes 0x00..0x08.
  - Required: DataInReady=0 after the 8th push, tx_count=8, tx_overflow=1, and 0x08 is absent when the FIFO is drained.
- RX wrap-around with concurrent traffic:
  - Stream 20 rx bytes 0x10..0x23 while popping one byte every cycle after the first.
  - Required: DataOut yields 0x10..0x23 in order, rx_count never exceeds 1, and rx_overflow=0.
- Full with simultaneous push and pop:
  - Fill the RX FIFO to 8, then assert rx_valid (0x99) and DataOutReady in the same cycle.
  - Required: rx_count=7, 0x99 dropped, rx_overflow=1.
  - Then in one cycle assert ovf_clear with rx_valid and the FIFO not full. Required: rx_overflow=0, rx_count=8.
- Reset mid-operation:
  - With both FIFOs holding 5 bytes, pulse reset_n=0 for 1 cycle.
  - Required: counts=0 and valids=0 next cycle.
  - A subsequent push of 0x55 appears as tx_data=0x55 one cycle later.
